// File: rtl/seq_slice_comparator.sv
// Multi-cycle magnitude comparator: scans WIDTH-bit operands SLICE bits per cycle, MSB slice first.
// Optional macro CMP_SIGNED_EN enables two's-complement compares through the is_signed input.
module seq_slice_comparator #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             a_lt,
    output logic             a_eq,
    output logic             a_gt
);

    localparam int NSLICE = (SLICE > 0) ? WIDTH / SLICE : 1;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (WIDTH < 1 || SLICE < 1) begin : g_bad_size
            $error("seq_slice_comparator: WIDTH and SLICE must be at least 1");
        end else if (WIDTH % SLICE != 0) begin : g_bad_slice
            $error("seq_slice_comparator: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] a_cap;
    logic [WIDTH-1:0] b_cap;
    logic [SLICE-1:0] a_top;
    logic [SLICE-1:0] b_top;

`ifdef CMP_SIGNED_EN
    // Flipping both MSBs biases two's-complement values so the unsigned scan gives signed order.
    localparam logic [WIDTH-1:0] MSB_MASK = ~({WIDTH{1'b1}} >> 1);
    assign a_cap = is_signed ? (a ^ MSB_MASK) : a;
    assign b_cap = is_signed ? (b ^ MSB_MASK) : b;
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
    assign a_cap = a;
    assign b_cap = b;
`endif

    // Operands shift left each step, so the slice under test is always the top one.
    assign a_top = a_q[WIDTH-1 -: SLICE];
    assign b_top = b_q[WIDTH-1 -: SLICE];

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            a_lt  <= 1'b0;
            a_eq  <= 1'b0;
            a_gt  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q   <= a_cap;
                        b_q   <= b_cap;
                        idx   <= IDXW'(NSLICE - 1);
                        a_lt  <= 1'b0;
                        a_eq  <= 1'b0;
                        a_gt  <= 1'b0;
                        state <= S_RUN;
                    end else if (state == S_DONE) begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (a_top < b_top) begin
                        a_lt  <= 1'b1;
                        state <= S_DONE;
                    end else if (a_top > b_top) begin
                        a_gt  <= 1'b1;
                        state <= S_DONE;
                    end else if (idx == '0) begin
                        a_eq  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                        a_q <= a_q << SLICE;
                        b_q <= b_q << SLICE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_slice_comparator.md
# seq_slice_comparator

Parametrised multi-cycle magnitude comparator that generalises the divider's single-cycle 32-bit less-than comparator. It scans two WIDTH-bit operands SLICE bits per cycle, MSB slice first, and terminates early at the first differing slice. It returns a one-hot less/equal/greater result with a start/busy/done handshake, and an optional signed mode. It sits beside the divider datapath and lets wide operands be compared without a WIDTH-deep combinational chain.

## Interface
- WIDTH, 32, operand width in bits; must be ≥ 1.
- SLICE, 8, bits compared per cycle; WIDTH % SLICE must be 0, otherwise elaboration fails. NSLICE = WIDTH/SLICE.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a compare; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- is_signed  in  1  1 = two's-complement compare; captured with operands.
- busy  out  1  high while in RUN.
- done  out  1  high for exactly one cycle (state DONE).
- a_lt  out  1  A < B.
- a_eq  out  1  A == B.
- a_gt  out  1  A > B.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE with start=1: register a, b, and is_signed; set idx = NSLICE-1; clear a_lt/a_eq/a_gt to 000; go to RUN.
- DONE with start=0: go to IDLE.
- RUN, per cycle, compare slice idx (bits idx*SLICE+SLICE-1 .. idx*SLICE) of the captured operands as unsigned:
  - slice A < slice B: a_lt=1, go to DONE.
  - slice A > slice B: a_gt=1, go to DONE.
  - equal and idx==0: a_eq=1, go to DONE.
  - equal otherwise: idx decrements; stay in RUN.
- Signed mode: the MSB of both captured operands is inverted before the top slice is compared. This is a bias transform, so the unsigned scan yields the signed order.
- In RUN, start is ignored. Operand inputs are don't-care after capture.
- Result flags are one-hot after completion, 000 between accept and completion. They hold until the next accepted start.

## Timing
- Reset values: busy=0, done=0, a_lt=0, a_eq=0, a_gt=0. State is IDLE and idx=0.
- Reset takes effect immediately, including mid-RUN. No result is produced for the aborted compare.
- Let k be the number of slices examined, 1 ≤ k ≤ NSLICE (k is the index from the top of the first differing slice, else NSLICE).
- The start-accepting edge is E0. busy is high from E0 to Ek. Results and done are registered at Ek. done is high for one cycle after Ek.
- Latency is k cycles from the accept edge to done. Worst case is NSLICE cycles (equal operands, or a difference only in slice 0).
- Back-to-back: start high during the done cycle is accepted at that edge. Next result flags read 000 in the following cycle. Sustained throughput is one compare per k+1 cycles.
- SLICE == WIDTH: every compare completes in 1 cycle.

## Configuration
- CMP_SIGNED_EN defined: is_signed is honoured as described under Operation.
- CMP_SIGNED_EN undefined: the is_signed port still exists but is ignored, and every compare is unsigned. No MSB inversion logic is built.

## Test plan
- WIDTH=32, SLICE=8, unsigned, a=0x1234_5678, b=0x1234_5679 → busy for 4 cycles, done 4 cycles after the accept edge, a_lt=1, a_eq=0, a_gt=0.
- a=0x8000_0000, b=0x0000_0001, is_signed=0 → a_gt=1 after 1 cycle. With CMP_SIGNED_EN and is_signed=1 → a_lt=1 after 1 cycle. Without the macro and is_signed=1 → a_gt=1.
- a=b=0xDEAD_BEEF → a_eq=1, done after 4 cycles. Then a=0x0000_0100, b=0x0000_00FF → a_gt=1 after 3 cycles.
- start pulsed while busy with a different operand pair → ignored, original result returned. start held high during done → new compare accepted, flags read 000 in the next cycle, then the correct new result.
- rst_n driven low for 1 cycle during RUN → all outputs 0 immediately, state IDLE. A subsequent start with 0x0000_0005 vs 0x0000_0005 gives a_eq=1 after 4 cycles.
- WIDTH=64, SLICE=64, a=0xFFFF_FFFF_FFFF_FFFF, b=0 → a_gt=1, done 1 cycle after accept. WIDTH=30, SLICE=8 → elaboration error.
